cardinal_nic_fifo: RTL and testbench

CARDINAL_NIC_FIFO -- requirements
Module: cardinal_nic_fifo

---
 rtl/cardinal_nic_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_cardinal_nic_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic_fifo.sv
// rtl/cardinal_nic_fifo.sv - PE-facing NIC with independent input and output packet FIFOs
module cardinal_nic_fifo #(
   parameter int PAC_WIDTH = 64,
   parameter int DEPTH     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [0:1]           addr,
   input  logic [0:PAC_WIDTH-1] d_in,
   output logic [0:PAC_WIDTH-1] d_out,
   input  logic                 nicEn,
   input  logic                 nicWrEn,
   input  logic                 net_si,
   output logic                 net_ri,
   input  logic [0:PAC_WIDTH-1] net_di,
   output logic                 net_so,
   input  logic                 net_ro,
   output logic [0:PAC_WIDTH-1] net_do,
   input  logic                 net_polarity
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Register map selects
   localparam logic [0:1] ADDR_IN_DATA  = 2'b00;
   localparam logic [0:1] ADDR_IN_STAT  = 2'b01;
   localparam logic [0:1] ADDR_OUT_DATA = 2'b10;
   localparam logic [0:1] ADDR_OUT_STAT = 2'b11;

   // Input FIFO (network -> PE)
   logic [0:PAC_WIDTH-1] r_in_mem [DEPTH];
   logic [PTR_W-1:0]     r_in_rd;
   logic [PTR_W-1:0]     r_in_wr;
   logic [CNT_W-1:0]     r_in_cnt;
   logic                 r_in_udf;

   // Output FIFO (PE -> network)
   logic [0:PAC_WIDTH-1] r_out_mem [DEPTH];
   logic [PTR_W-1:0]     r_out_rd;
   logic [PTR_W-1:0]     r_out_wr;
   logic [CNT_W-1:0]     r_out_cnt;
   logic                 r_out_ovf;

   logic                 w_pe_rd;
   logic                 w_pe_wr;
   logic                 w_in_empty;
   logic                 w_in_full;
   logic                 w_out_empty;
   logic                 w_out_full;
   logic                 w_in_push;
   logic                 w_in_pop;
   logic                 w_in_udf_evt;
   logic                 w_in_stat_rd;
   logic                 w_out_push;
   logic                 w_out_pop;
   logic                 w_out_ovf_evt;
   logic                 w_out_stat_rd;
   logic [0:PAC_WIDTH-1] w_in_head;
   logic [0:PAC_WIDTH-1] w_out_head;
   logic [0:PAC_WIDTH-1] w_in_status;
   logic [0:PAC_WIDTH-1] w_out_status;

   assign w_pe_rd = nicEn && !nicWrEn;
   assign w_pe_wr = nicEn &&  nicWrEn;

   assign w_in_empty  = (r_in_cnt  == '0);
   assign w_in_full   = (r_in_cnt  == FULL_CNT);
   assign w_out_empty = (r_out_cnt == '0);
   assign w_out_full  = (r_out_cnt == FULL_CNT);

   // Ready depends only on registered occupancy so the router never sees a combinational loop
   assign net_ri = !w_in_full;

   assign w_in_push     = net_si && net_ri;
   assign w_in_pop      = w_pe_rd && (addr == ADDR_IN_DATA) && !w_in_empty;
   assign w_in_udf_evt  = w_pe_rd && (addr == ADDR_IN_DATA) &&  w_in_empty;
   assign w_in_stat_rd  = w_pe_rd && (addr == ADDR_IN_STAT);

   // A full FIFO refuses the write even if the router drains it this cycle
   assign w_out_push    = w_pe_wr && (addr == ADDR_OUT_DATA) && !w_out_full;
   assign w_out_ovf_evt = w_pe_wr && (addr == ADDR_OUT_DATA) &&  w_out_full;
   assign w_out_stat_rd = w_pe_rd && (addr == ADDR_OUT_STAT);

   assign w_in_head  = w_in_empty  ? '0 : r_in_mem[r_in_rd];
   assign w_out_head = w_out_empty ? '0 : r_out_mem[r_out_rd];

   assign net_do = w_out_head;

   // Only send packets whose VC bit differs from the current router polarity; nothing leaves during reset
   assign net_so    = reset && net_ro && !w_out_empty && (w_out_head[0] != net_polarity);
   assign w_out_pop = net_so;

   // Input status word: non-empty flag in the last bit, count just above it, underflow in bit 0
   always_comb begin
      w_in_status = '0;
      w_in_status[PAC_WIDTH-1] = !w_in_empty;
      w_in_status[PAC_WIDTH-1-CNT_W:PAC_WIDTH-2] = r_in_cnt;
      w_in_status[0] = r_in_udf;
   end

   // Output status word: full flag in the last bit, count just above it, overflow in bit 0
   always_comb begin
      w_out_status = '0;
      w_out_status[PAC_WIDTH-1] = w_out_full;
      w_out_status[PAC_WIDTH-1-CNT_W:PAC_WIDTH-2] = r_out_cnt;
      w_out_status[0] = r_out_ovf;
   end

   // PE register read mux; anything other than a read returns zero
   always_comb begin
      d_out = '0;
      if (w_pe_rd) begin
         case (addr)
            ADDR_IN_DATA:  d_out = w_in_head;
            ADDR_IN_STAT:  d_out = w_in_status;
            ADDR_OUT_STAT: d_out = w_out_status;
            default:       d_out = '0;
         endcase
      end
   end

   // Input FIFO storage; contents are don't-care once the count says empty, so no reset
   always_ff @(posedge clk) begin
      if (reset && w_in_push) begin
         r_in_mem[r_in_wr] <= net_di;
      end
   end

   // Input FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_in_rd  <= '0;
         r_in_wr  <= '0;
         r_in_cnt <= '0;
      end else begin
         if (w_in_push) begin
            r_in_wr <= r_in_wr + PTR_ONE;
         end
         if (w_in_pop) begin
            r_in_rd <= r_in_rd + PTR_ONE;
         end
         case ({w_in_push, w_in_pop})
            2'b10:   r_in_cnt <= r_in_cnt + CNT_ONE;
            2'b01:   r_in_cnt <= r_in_cnt - CNT_ONE;
            default: r_in_cnt <= r_in_cnt;
         endcase
      end
   end

   // Sticky underflow: a new empty read wins over the clear-on-status-read
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_in_udf <= 1'b0;
      end else if (w_in_udf_evt) begin
         r_in_udf <= 1'b1;
      end else if (w_in_stat_rd) begin
         r_in_udf <= 1'b0;
      end
   end

   // Output FIFO storage; written only on an accepted PE write
   always_ff @(posedge clk) begin
      if (reset && w_out_push) begin
         r_out_mem[r_out_wr] <= d_in;
      end
   end

   // Output FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out_rd  <= '0;
         r_out_wr  <= '0;
         r_out_cnt <= '0;
      end else begin
         if (w_out_push) begin
            r_out_wr <= r_out_wr + PTR_ONE;
         end
         if (w_out_pop) begin
            r_out_rd <= r_out_rd + PTR_ONE;
         end
         case ({w_out_push, w_out_pop})
            2'b10:   r_out_cnt <= r_out_cnt + CNT_ONE;
            2'b01:   r_out_cnt <= r_out_cnt - CNT_ONE;
            default: r_out_cnt <= r_out_cnt;
         endcase
      end
   end

   // Sticky overflow: a new dropped write wins over the clear-on-status-read
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out_ovf <= 1'b0;
      end else if (w_out_ovf_evt) begin
         r_out_ovf <= 1'b1;
      end else if (w_out_stat_rd) begin
         r_out_ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// tb/tb_cardinal_nic_fifo.sv - scoreboard bench for cardinal_nic_fifo
module tb_cardinal_nic_fifo;

   localparam int PW = 64;
   localparam int DP = 4;

   logic          clk;
   logic          reset;
   logic [0:1]    addr;
   logic [0:PW-1] d_in;
   logic [0:PW-1] d_out;
   logic          nicEn;
   logic          nicWrEn;
   logic          net_si;
   logic          net_ri;
   logic [0:PW-1] net_di;
   logic          net_so;
   logic          net_ro;
   logic [0:PW-1] net_do;
   logic          net_polarity;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] in_q[$];
   logic [63:0] out_q[$];
   logic        m_udf = 1'b0;
   logic        m_ovf = 1'b0;

   cardinal_nic_fifo #(.PAC_WIDTH(PW), .DEPTH(DP)) dut (
      .clk          (clk),
      .reset        (reset),
      .addr         (addr),
      .d_in         (d_in),
      .d_out        (d_out),
      .nicEn        (nicEn),
      .nicWrEn      (nicWrEn),
      .net_si       (net_si),
      .net_ri       (net_ri),
      .net_di       (net_di),
      .net_so       (net_so),
      .net_ro       (net_ro),
      .net_do       (net_do),
      .net_polarity (net_polarity)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Numeric view: spec bit 0 is numeric bit 63, spec bit 63 is numeric bit 0
   function automatic logic [63:0] status_word(input logic top, input int cnt, input logic flag);
      logic [63:0] v;
      logic [2:0]  c;
      c     = cnt[2:0];
      v     = '0;
      v[0]  = top;
      v[3:1] = c;
      v[63] = flag;
      return v;
   endfunction

   task automatic idle_inputs;
      nicEn   = 1'b0;
      nicWrEn = 1'b0;
      addr    = 2'b00;
      d_in    = '0;
      net_si  = 1'b0;
      net_di  = '0;
   endtask

   // One clock: check outputs at the falling edge against the queue model, then advance the model
   task automatic cycle(input string tag);
      logic [63:0] exp_dout, exp_do, din_v, ndi_v;
      logic        exp_so, exp_ri, rd, wr;
      bit          in_push, in_pop, out_push;
      @(negedge clk);
      rd     = nicEn && !nicWrEn;
      wr     = nicEn &&  nicWrEn;
      exp_ri = (in_q.size() != DP);
      exp_do = (out_q.size() != 0) ? out_q[0] : 64'h0;
      exp_so = reset && net_ro && (out_q.size() != 0) && (exp_do[63] != net_polarity);
      exp_dout = 64'h0;
      if (rd) begin
         case (addr)
            2'b00: exp_dout = (in_q.size() != 0) ? in_q[0] : 64'h0;
            2'b01: exp_dout = status_word(in_q.size() != 0, in_q.size(), m_udf);
            2'b11: exp_dout = status_word(out_q.size() == DP, out_q.size(), m_ovf);
            default: exp_dout = 64'h0;
         endcase
      end
      check_eq($sformatf("%s.d_out", tag), d_out, exp_dout);
      check_eq($sformatf("%s.net_ri", tag), {63'h0, net_ri}, {63'h0, exp_ri});
      check_eq($sformatf("%s.net_so", tag), {63'h0, net_so}, {63'h0, exp_so});
      check_eq($sformatf("%s.net_do", tag), net_do, exp_do);
      din_v = d_in;
      ndi_v = net_di;
      if (!reset) begin
         in_q.delete();
         out_q.delete();
         m_udf = 1'b0;
         m_ovf = 1'b0;
      end else begin
         in_push  = net_si && exp_ri;
         in_pop   = rd && (addr == 2'b00) && (in_q.size() != 0);
         out_push = wr && (addr == 2'b10) && (out_q.size() != DP);
         if (rd && addr == 2'b00 && in_q.size() == 0) m_udf = 1'b1;
         else if (rd && addr == 2'b01)                 m_udf = 1'b0;
         if (wr && addr == 2'b10 && out_q.size() == DP) m_ovf = 1'b1;
         else if (rd && addr == 2'b11)                   m_ovf = 1'b0;
         if (in_pop)   void'(in_q.pop_front());
         if (in_push)  in_q.push_back(ndi_v);
         if (exp_so)   void'(out_q.pop_front());
         if (out_push) out_q.push_back(din_v);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic net_push(input logic [63:0] v);
      net_si = 1'b1;
      net_di = v;
      cycle("net_push");
      idle_inputs();
   endtask

   task automatic pe_read(input logic [1:0] a, input string tag);
      nicEn   = 1'b1;
      nicWrEn = 1'b0;
      addr    = a;
      cycle(tag);
      idle_inputs();
   endtask

   task automatic pe_write(input logic [63:0] v);
      nicEn   = 1'b1;
      nicWrEn = 1'b1;
      addr    = 2'b10;
      d_in    = v;
      cycle("pe_write");
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      net_ro       = 1'b0;
      net_polarity = 1'b0;
      reset        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      // Reset state
      check_eq("rst.net_ri", {63'h0, net_ri}, 64'h1);
      check_eq("rst.net_so", {63'h0, net_so}, 64'h0);
      check_eq("rst.net_do", net_do, 64'h0);
      check_eq("rst.d_out", d_out, 64'h0);
      cycle("idle");
      pe_read(2'b01, "rst_st_in");
      pe_read(2'b11, "rst_st_out");

      // Fill input FIFO, then read status and drain in order
      for (int i = 1; i <= 4; i++) net_push(64'(i));
      check_eq("full.net_ri", {63'h0, net_ri}, 64'h0);
      nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b01;
      #2;
      check_eq("full.st_in", d_out, 64'h0000_0000_0000_0009);
      cycle("full_st_in");
      idle_inputs();
      for (int i = 0; i < 4; i++) pe_read(2'b00, "drain_in");

      // Underflow: empty read, sticky flag, clear on status read, pointers untouched
      pe_read(2'b00, "udf_rd");
      net_push(64'hAA);
      nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b01;
      #2;
      check_eq("udf.st_in", d_out, 64'h8000_0000_0000_0003);
      cycle("udf_st1");
      idle_inputs();
      pe_read(2'b01, "udf_st2");
      pe_read(2'b00, "udf_data");

      // VC polarity gating of net_so
      net_ro = 1'b1;
      net_polarity = 1'b1;
      pe_write(64'h8000_0000_0000_0001);
      for (int i = 0; i < 3; i++) cycle("vc_hold");
      check_eq("vc.net_do", net_do, 64'h8000_0000_0000_0001);
      net_polarity = 1'b0;
      cycle("vc_send");
      cycle("vc_after");

      // Output overflow, sticky clear, and full FIFO refusing a write while draining
      net_ro = 1'b0;
      net_polarity = 1'b1;
      for (int i = 0; i < 5; i++) pe_write(64'h10 + 64'(i));
      nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b11;
      #2;
      check_eq("ovf.st_out", d_out, 64'h8000_0000_0000_0009);
      cycle("ovf_st1");
      idle_inputs();
      pe_read(2'b11, "ovf_st2");
      net_ro = 1'b1;
      pe_write(64'h15);
      net_ro = 1'b0;
      pe_read(2'b11, "nobypass_st");
      net_ro = 1'b1;
      for (int i = 0; i < 4; i++) cycle("drain_out");

      // Simultaneous push/pop at count 2 with pointer wrap
      net_ro = 1'b0;
      net_push(64'h100);
      net_push(64'h101);
      for (int i = 0; i < 10; i++) begin
         net_si  = 1'b1;
         net_di  = 64'h200 + 64'(i);
         nicEn   = 1'b1;
         nicWrEn = 1'b0;
         addr    = 2'b00;
         cycle("pushpop");
      end
      idle_inputs();
      nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'b01;
      #2;
      check_eq("pp.st_in", d_out, 64'h0000_0000_0000_0005);
      cycle("pp_st");
      idle_inputs();
      pe_read(2'b00, "pp_drain");
      pe_read(2'b00, "pp_drain");

      // Reset mid-transfer with both FIFOs holding three packets
      for (int i = 0; i < 3; i++) net_push(64'h300 + 64'(i));
      for (int i = 0; i < 3; i++) pe_write(64'h400 + 64'(i));
      net_ro       = 1'b1;
      net_polarity = 1'b1;
      net_si       = 1'b1;
      net_di       = 64'hDEAD;
      reset        = 1'b0;
      cycle("rst_mid");
      reset = 1'b1;
      idle_inputs();
      check_eq("rstm.net_ri", {63'h0, net_ri}, 64'h1);
      check_eq("rstm.net_so", {63'h0, net_so}, 64'h0);
      cycle("rstm_idle");
      pe_read(2'b01, "rstm_st_in");
      pe_read(2'b11, "rstm_st_out");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
